// File: rtl/toggle_event_rx.sv
// Receive side of a toggle-encoded event link: synchronises the toggle level, emits one pulse per
// transition and accumulates events in a saturating counter behind a ready/valid port.
module toggle_event_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             t_in,
  output logic             evt_pulse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

  typedef enum logic [0:0] {StEmpty, StPending} state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   tp_q, tp_d;
  logic                   evt_pulse_q, evt_pulse_d;
  logic                   out_valid_q, out_valid_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   ts, evt;

  assign ts  = sync_q[SYNC_STAGES-1];
  assign evt = ts ^ tp_q;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], t_in};
    tp_d        = ts;
    evt_pulse_d = evt;
    state_d     = state_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    case (state_q)
      StEmpty: begin
        if (evt) begin
          state_d = StPending;
          count_d = CntOne;
        end
      end
      StPending: begin
        if (out_ready) begin
          // An event arriving on the accept edge starts the next batch instead of being dropped.
          overflow_d = 1'b0;
          if (evt) begin
            count_d = CntOne;
          end else begin
            count_d = '0;
            state_d = StEmpty;
          end
        end else if (evt) begin
          if (count_q == CntMax) begin
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CntOne;
          end
        end
      end
      default: begin
        state_d    = StEmpty;
        count_d    = '0;
        overflow_d = 1'b0;
      end
    endcase
    out_valid_d = (state_d == StPending);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      sync_q      <= '0;
      tp_q        <= 1'b0;
      evt_pulse_q <= 1'b0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      tp_q        <= tp_d;
      evt_pulse_q <= evt_pulse_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt_pulse = evt_pulse_q;
  assign out_valid = out_valid_q;
  assign out_count = count_q;
  assign overflow  = overflow_q;

endmodule
